// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// and the wait-counter width.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Wide enough for the largest legal TIMEOUT (255)
  localparam int WAIT_W = 8;

  function automatic int size_bytes(lsu_size_e s);
    return 1 << s;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between a requester (master) and the
// load/store unit (slave).
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  lsu_size_e         req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables, store lane shift, load
// extract/extend, plus alignment and size legality checks.
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  lsu_size_e         size,
  input  logic              sgn,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              misaligned,
  output logic              illegal
);

  int                nb;
  logic [BE_W-1:0]   base_be;
  logic [DATA_W-1:0] keep;
  logic [DATA_W-1:0] sh;
  logic [OFF_W-1:0]  amask;
  logic              msb;

  always_comb begin
    nb      = size_bytes(size);
    base_be = '0;
    keep    = '0;
    for (int b = 0; b < BE_W; b++) begin
      base_be[b]     = (b < nb);
      keep[b*8 +: 8] = {8{b < nb}};
    end
    be         = base_be << off;
    amask      = OFF_W'(nb - 1);
    misaligned = |(off & amask);
    illegal    = (size == SZ_DWORD) && (DATA_W != 64);

    // Store data is right-justified; drop bits above the access size
    wdata_sh = (wdata & keep) << {off, 3'b000};

    sh = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: msb = sh[7];
      SZ_HALF: msb = sh[15];
      SZ_WORD: msb = sh[31];
      default: msb = sh[DATA_W-1];
    endcase
    rdata_ext = (sh & keep) | (~keep & {DATA_W{sgn & msb}});
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: latches one request, runs one memory
// access with an ack timeout, and returns a one-cycle response.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | req_ready=1, waiting for req_valid
// ST_ACCESS | mem_en held with stable be/addr/wdata until ack or timeout
// ST_RESP   | rsp_valid pulse for one cycle, then back to IDLE
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  load_store_unit_if.slave       bus,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [DATA_W/8-1:0]    mem_be,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_ack
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(DATA_W / 8);

  lsu_state_e        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lat_we;
  lsu_size_e         lat_size;
  logic              lat_signed;
  logic [OFF_W-1:0]  lat_off;

  lsu_size_e         al_size;
  logic              al_sgn;
  logic [OFF_W-1:0]  al_off;
  logic [BE_W-1:0]   al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;
  logic              al_misaligned;
  logic              al_illegal;

  // Aligner looks at the live request while idle, the latched one afterwards
  assign al_size = (state == ST_IDLE) ? bus.req_size   : lat_size;
  assign al_sgn  = (state == ST_IDLE) ? bus.req_signed : lat_signed;
  assign al_off  = (state == ST_IDLE) ? bus.req_addr[OFF_W-1:0] : lat_off;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .size       (al_size),
    .sgn        (al_sgn),
    .off        (al_off),
    .wdata      (bus.req_wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata_sh   (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      lat_we        <= 1'b0;
      lat_size      <= SZ_BYTE;
      lat_signed    <= 1'b0;
      lat_off       <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_be        <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            lat_we        <= bus.req_we;
            lat_size      <= bus.req_size;
            lat_signed    <= bus.req_signed;
            lat_off       <= bus.req_addr[OFF_W-1:0];
            bus.req_ready <= 1'b0;
            if (al_misaligned || al_illegal) begin
              state         <= ST_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state     <= ST_ACCESS;
              wait_cnt  <= '0;
              mem_en    <= 1'b1;
              mem_we    <= bus.req_we;
              mem_be    <= al_be;
              mem_addr  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wdata <= al_wdata;
            end
          end
        end
        ST_ACCESS: begin
          // Ack takes priority over a coincident timeout
          if (mem_ack || (wait_cnt == WAIT_W'(TIMEOUT - 1))) begin
            state         <= ST_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= !mem_ack;
            bus.rsp_rdata <= (mem_ack && !lat_we) ? al_rdata : '0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_be        <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (32-bit data, TIMEOUT=4).
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; returns just after the accepting edge
  task automatic issue(input logic we, input lsu_size_e size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  // Acks in the current ACCESS cycle, then checks the response cycle
  task automatic ack_and_check(input string tag, input logic [31:0] rdata,
                               input logic [31:0] exp_rdata);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    chk({tag, "_rsp_err"},   bus.rsp_err,   0);
    chk({tag, "_mem_en_off"}, mem_en, 0);
    tick();
    chk({tag, "_rsp_pulse"}, bus.rsp_valid, 0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = SZ_BYTE;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    mem_ack        = 1'b0;
    mem_rdata      = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_mem_en",    mem_en, 0);
    chk("rst_mem_we",    mem_we, 0);
    chk("rst_mem_be",    mem_be, 0);
    chk("rst_mem_addr",  mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err",   bus.rsp_err, 0);

    // Stray ack while idle
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack   = 1'b0;
    chk("idle_ack_rsp_valid", bus.rsp_valid, 0);
    chk("idle_ack_ready",     bus.req_ready, 1);
    chk("idle_ack_mem_en",    mem_en, 0);

    // LW 0x10, zero waits
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("lw_mem_en",    mem_en, 1);
    chk("lw_mem_we",    mem_we, 0);
    chk("lw_mem_addr",  mem_addr, 32'h10);
    chk("lw_mem_be",    mem_be, 4'hF);
    chk("lw_busy",      bus.req_ready, 0);
    chk("lw_early_rsp", bus.rsp_valid, 0);
    ack_and_check("lw", 32'h8899AABB, 32'h8899AABB);
    chk("lw_hold_rdata", bus.rsp_rdata, 32'h8899AABB);
    chk("lw_ready_back", bus.req_ready, 1);

    // LB at 0x22, signed then unsigned
    issue(1'b0, SZ_BYTE, 1'b1, 32'h22, 32'h0);
    chk("lbs_mem_be",   mem_be, 4'b0100);
    chk("lbs_mem_addr", mem_addr, 32'h20);
    ack_and_check("lbs", 32'h00F00000, 32'hFFFFFFF0);
    issue(1'b0, SZ_BYTE, 1'b0, 32'h22, 32'h0);
    chk("lbu_mem_be", mem_be, 4'b0100);
    ack_and_check("lbu", 32'h00F00000, 32'h000000F0);

    // LH at 0x02, signed then unsigned
    issue(1'b0, SZ_HALF, 1'b1, 32'h02, 32'h0);
    chk("lhs_mem_be", mem_be, 4'b1100);
    ack_and_check("lhs", 32'h80010000, 32'hFFFF8001);
    issue(1'b0, SZ_HALF, 1'b0, 32'h02, 32'h0);
    ack_and_check("lhu", 32'h80010000, 32'h00008001);

    // SH 0x1234 to 0x06; read data on the bus must not leak into the response
    issue(1'b1, SZ_HALF, 1'b0, 32'h06, 32'hFFFF1234);
    chk("sh_mem_en",    mem_en, 1);
    chk("sh_mem_we",    mem_we, 1);
    chk("sh_mem_addr",  mem_addr, 32'h04);
    chk("sh_mem_be",    mem_be, 4'b1100);
    chk("sh_mem_wdata", mem_wdata, 32'h12340000);
    ack_and_check("sh", 32'hCAFEF00D, 32'h0);

    // SB 0xA5 to 0x01
    issue(1'b1, SZ_BYTE, 1'b0, 32'h01, 32'h000000A5);
    chk("sb_mem_be",    mem_be, 4'b0010);
    chk("sb_mem_wdata", mem_wdata, 32'h0000A500);
    ack_and_check("sb", 32'h0, 32'h0);

    // LW at 0x10 to give rsp_rdata a nonzero value before the error case
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    ack_and_check("lw2", 32'h01020304, 32'h01020304);

    // Misaligned LW 0x03: response the very next cycle, no memory strobe
    issue(1'b0, SZ_WORD, 1'b0, 32'h03, 32'h0);
    chk("mis_rsp_valid", bus.rsp_valid, 1);
    chk("mis_rsp_err",   bus.rsp_err, 1);
    chk("mis_rsp_rdata", bus.rsp_rdata, 0);
    chk("mis_mem_en",    mem_en, 0);
    tick();
    chk("mis_pulse", bus.rsp_valid, 0);
    chk("mis_hold_err", bus.rsp_err, 1);

    // Misaligned half and illegal dword on a 32-bit path
    issue(1'b0, SZ_HALF, 1'b0, 32'h05, 32'h0);
    chk("mish_rsp_err", bus.rsp_err, 1);
    chk("mish_mem_en",  mem_en, 0);
    tick();
    issue(1'b0, SZ_DWORD, 1'b0, 32'h00, 32'h0);
    chk("dw_rsp_valid", bus.rsp_valid, 1);
    chk("dw_rsp_err",   bus.rsp_err, 1);
    chk("dw_mem_en",    mem_en, 0);
    tick();

    // Timeout: no ack for 4 ACCESS cycles
    issue(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_mem_en_wait", mem_en, 1);
      chk("to_no_rsp",      bus.rsp_valid, 0);
      tick();
    end
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_rsp_err",   bus.rsp_err, 1);
    chk("to_rsp_rdata", bus.rsp_rdata, 0);
    chk("to_mem_en",    mem_en, 0);
    tick();

    // Ack on the 4th ACCESS cycle wins over the timeout
    issue(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("ack4_mem_en_wait", mem_en, 1);
      chk("ack4_addr_stable", mem_addr, 32'h40);
      tick();
    end
    ack_and_check("ack4", 32'h11223344, 32'h11223344);

    // Reset mid-access abandons the access without a response
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("rma_mem_en", mem_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rma_mem_en_off", mem_en, 0);
    chk("rma_no_rsp",     bus.rsp_valid, 0);
    chk("rma_ready",      bus.req_ready, 1);
    chk("rma_rdata_clr",  bus.rsp_rdata, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rma_late_ack", bus.rsp_valid, 0);
    issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("rma_lw_mem_en", mem_en, 1);
    ack_and_check("rma_lw", 32'h8899AABB, 32'h8899AABB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_W, default 32, data path width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter TIMEOUT, default 15, max wait cycles for mem_ack before error; legal range 1..255.
REQ-004 CLK  input  1  single system clock, all state updates on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  unit can accept request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64).
REQ-010 req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-011 req_addr  input  ADDR_W  byte address.
REQ-012 req_wdata  input  DATA_W  store data, right-justified.
REQ-013 mem_en / mem_we  output  1 each  memory access strobe / write enable.
REQ-014 mem_be  output  DATA_W/8  byte lane enables.
REQ-015 mem_addr  output  ADDR_W  address aligned down to DATA_W/8 bytes.
REQ-016 mem_wdata  output  DATA_W  store data shifted to its byte lanes.
REQ-017 mem_rdata  input  DATA_W; mem_ack  input  1  read data / access complete.
REQ-018 rsp_valid  output  1; rsp_rdata  output  DATA_W; rsp_err  output  1  completion, load result, error flag.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 IDLE with req_valid: request latched; if misaligned (addr mod size-bytes != 0) or illegal size -> RESP with rsp_err=1 and no memory access; else -> ACCESS.
REQ-021 ACCESS: mem_en=1, mem_we=latched we, mem_be/mem_addr/mem_wdata stable for the whole state; on mem_ack -> RESP.
REQ-022 Wait counter SHALL clear on entering ACCESS, increment each ACCESS cycle without mem_ack; reaching TIMEOUT without ack -> RESP with rsp_err=1, mem_en deasserted.
REQ-023 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-024 Load data SHALL be taken from mem_rdata on the ack cycle, shifted by byte offset, then sign/zero-extended to DATA_W per req_signed.
REQ-025 RESP: rsp_valid=1 for exactly one cycle, then -> IDLE; rsp_rdata=0 for stores and errors.
REQ-026 Latency: request accepted cycle N, ack in first ACCESS cycle N+1 -> rsp_valid at N+2; each wait cycle adds 1.
REQ-027 mem_ack outside ACCESS SHALL be ignored.
REQ-028 rsp_rdata and rsp_err SHALL hold their values until the next RESP.

Reset
REQ-029 RST asserted SHALL force IDLE on the next edge regardless of state, abandoning any access mid-ACCESS with no response.
REQ-030 Reset values: req_ready=1 after reset completes, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.

Structure
REQ-031 Shared package SHALL hold the size encodings and FSM state encoding.
REQ-032 One sub-module lsu_align SHALL contain the combinational byte-enable generation, store lane shift and load extract/extend.

Verification
REQ-033 Load word: mem preset 0x8899AABB at 0x10, LW 0x10, ack after 0 waits -> rsp_valid at cycle N+2, rsp_rdata=0x8899AABB, rsp_err=0.
REQ-034 Byte load sign/zero: mem 0x00F0_0000 at 0x20; LB signed 0x22 -> 0xFFFFFFF0; unsigned -> 0x000000F0, mem_be=4'b0100.
REQ-035 Store half: SH 0x1234 to 0x06 -> mem_addr=0x04, mem_be=4'b1100, mem_wdata=0x12340000, mem_we=1.
REQ-036 Misaligned: LW 0x03 -> no mem_en pulse, rsp_valid at N+1 with rsp_err=1, rsp_rdata=0.
REQ-037 Timeout: TIMEOUT=4, never ack -> rsp_err=1 after 4 ACCESS cycles; repeat with ack on 4th cycle -> rsp_err=0.
REQ-038 Reset mid-access: RST during ACCESS -> next cycle IDLE, mem_en=0, no rsp_valid; next LW completes normally.
